// File: rtl/interrupt_sequencer.sv
// 6502 reset/NMI/IRQ/BRK entry sequencer: pushes PC and P, sets I, fetches the vector
// and hands the new PC to the control unit.
module interrupt_sequencer #(
    parameter logic [15:0] NMI_VEC    = 16'hFFFA,
    parameter logic [15:0] RST_VEC    = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
    parameter logic [7:0]  STACK_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        brk_req,
    input  logic        instr_boundary,
    input  logic        I_flag,
    input  logic [7:0]  P_in,
    input  logic [15:0] pc_in,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic        sp_dec,
    output logic        set_I,
    output logic        pc_load,
    output logic [15:0] pc_out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH_PCH = 3'd1,
        PUSH_PCL = 3'd2,
        PUSH_P   = 3'd3,
        VEC_LO   = 3'd4,
        VEC_HI   = 3'd5,
        LOAD     = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] vec_base_q, vec_base_d;
    logic [15:0] pc_q, pc_d;
    logic        b_q, b_d;
    logic        rst_path_q, rst_path_d;
    logic        nmi_s1_q, nmi_s1_d;
    logic        nmi_s2_q, nmi_s2_d;
    logic        nmi_prev_q, nmi_prev_d;
    logic        irq_s1_q, irq_s1_d;
    logic        irq_s2_q, irq_s2_d;
    logic        nmi_pend_q, nmi_pend_d;

    logic        nmi_edge_c;
    logic        irq_act_c;
    logic        nmi_clr_c;
    logic        set_i_c;

    // Stored B and bit 5 of the stack image are rebuilt here, not taken from P_in.
    logic        unused_p_bits;
    assign unused_p_bits = ^P_in[5:4];

    // State and capture registers; reset lands directly in the vector fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= VEC_LO;
            vec_base_q <= RST_VEC;
            pc_q       <= 16'h0000;
            b_q        <= 1'b0;
            rst_path_q <= 1'b1;
            nmi_s1_q   <= 1'b1;
            nmi_s2_q   <= 1'b1;
            nmi_prev_q <= 1'b1;
            irq_s1_q   <= 1'b1;
            irq_s2_q   <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_base_q <= vec_base_d;
            pc_q       <= pc_d;
            b_q        <= b_d;
            rst_path_q <= rst_path_d;
            nmi_s1_q   <= nmi_s1_d;
            nmi_s2_q   <= nmi_s2_d;
            nmi_prev_q <= nmi_prev_d;
            irq_s1_q   <= irq_s1_d;
            irq_s2_q   <= irq_s2_d;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    // Next state, request arbitration and Moore bus decode.
    always_comb begin
        state_d    = state_q;
        vec_base_d = vec_base_q;
        pc_d       = pc_q;
        b_d        = b_q;
        rst_path_d = rst_path_q;
        nmi_s1_d   = nmi_n;
        nmi_s2_d   = nmi_s1_q;
        nmi_prev_d = nmi_s2_q;
        irq_s1_d   = irq_n;
        irq_s2_d   = irq_s1_q;
        nmi_clr_c  = 1'b0;
        set_i_c    = 1'b0;

        busy      = (state_q != IDLE);
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        sp_dec    = 1'b0;
        pc_load   = 1'b0;
        pc_out    = pc_q;

        nmi_edge_c = nmi_prev_q & ~nmi_s2_q;
        irq_act_c  = ~irq_s2_q & ~I_flag;

        case (state_q)
            IDLE: begin
                if (instr_boundary && (nmi_pend_q || irq_act_c || brk_req)) begin
                    state_d    = PUSH_PCH;
                    vec_base_d = nmi_pend_q ? NMI_VEC : IRQ_VEC;
                    b_d        = brk_req;
                    rst_path_d = 1'b0;
                end
            end
            PUSH_PCH: begin
                mem_addr  = {STACK_PAGE, sp_in};
                mem_wdata = pc_in[15:8];
                mem_we    = 1'b1;
                sp_dec    = 1'b1;
                state_d   = PUSH_PCL;
            end
            PUSH_PCL: begin
                mem_addr  = {STACK_PAGE, sp_in};
                mem_wdata = pc_in[7:0];
                mem_we    = 1'b1;
                sp_dec    = 1'b1;
                state_d   = PUSH_P;
            end
            PUSH_P: begin
                mem_addr  = {STACK_PAGE, sp_in};
                mem_wdata = {P_in[7:6], 1'b1, b_q, P_in[3:0]};
                mem_we    = 1'b1;
                sp_dec    = 1'b1;
                set_i_c   = 1'b1;
                nmi_clr_c = (vec_base_q == NMI_VEC);
                state_d   = VEC_LO;
            end
            VEC_LO: begin
                mem_re   = 1'b1;
                mem_addr = vec_base_q;
                set_i_c  = rst_path_q;
                state_d  = VEC_HI;
            end
            VEC_HI: begin
                mem_re     = 1'b1;
                mem_addr   = vec_base_q + 16'd1;
                set_i_c    = rst_path_q;
                pc_d[7:0]  = mem_rdata;
                state_d    = LOAD;
            end
            LOAD: begin
                pc_d[15:8] = mem_rdata;
                pc_out     = {mem_rdata, pc_q[7:0]};
                pc_load    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge wins over the clear so it is never lost.
        nmi_pend_d = (nmi_pend_q & ~nmi_clr_c) | nmi_edge_c;
        set_I      = set_i_c & reset_n;
    end

endmodule
